// File: rtl/lsu_if.sv
// Execute-side handshake and data-memory bus signals of the sbmips load/store unit.
// slave is the unit's view; master is the view of whatever surrounds it.
interface lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_load;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [1:0]  out_exc;
    logic [31:0] out_badvaddr;

    modport slave (
        input  in_valid, in_op, in_addr, in_wdata, in_rd, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output out_valid, out_load, out_rd, out_data, out_exc, out_badvaddr
    );

    modport master (
        output in_valid, in_op, in_addr, in_wdata, in_rd, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  out_valid, out_load, out_rd, out_data, out_exc, out_badvaddr
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request/ack bus transaction per memory op, with
// alignment/opcode exceptions reported without touching the bus.
module lsu (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        out_valid_q, out_valid_d;
    logic        out_load_q, out_load_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_data_q, out_data_d;
    logic [1:0]  out_exc_q, out_exc_d;
    logic [31:0] out_badvaddr_q, out_badvaddr_d;

    logic        is_load, is_store, is_half, is_word, misaligned;
    logic [1:0]  exc_c;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] load_c;

    // Decode of the operation currently presented by execute.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        unique case (bus.in_op)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_load = 1'b1; is_word = 1'b1; end
            OP_SB:         is_store = 1'b1;
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
        misaligned = (is_half && bus.in_addr[0]) || (is_word && (bus.in_addr[1:0] != 2'b00));
        if (!is_load && !is_store) exc_c = 2'd3;
        else if (misaligned)       exc_c = is_load ? 2'd1 : 2'd2;
        else                       exc_c = 2'd0;
        if (is_word) begin
            be_c = 4'b1111;
            wd_c = bus.in_wdata;
        end else if (is_half) begin
            be_c = 4'b0011 << bus.in_addr[1:0];
            wd_c = {2{bus.in_wdata[15:0]}};
        end else begin
            be_c = 4'b0001 << bus.in_addr[1:0];
            wd_c = {4{bus.in_wdata[7:0]}};
        end
    end

    // Load extraction from the returned word using the latched op and lane.
    always_comb begin
        unique case (lane_q)
            2'd0:    byte_c = bus.mem_rdata[7:0];
            2'd1:    byte_c = bus.mem_rdata[15:8];
            2'd2:    byte_c = bus.mem_rdata[23:16];
            default: byte_c = bus.mem_rdata[31:24];
        endcase
        half_c = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        unique case (op_q)
            OP_LB:   load_c = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  load_c = {24'h0, byte_c};
            OP_LH:   load_c = {{16{half_c[15]}}, half_c};
            OP_LHU:  load_c = {16'h0, half_c};
            OP_LW:   load_c = bus.mem_rdata;
            default: load_c = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        lane_d         = lane_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_be_d       = mem_be_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        out_valid_d    = 1'b0;
        out_load_d     = out_load_q;
        out_rd_d       = out_rd_q;
        out_data_d     = out_data_q;
        out_exc_d      = out_exc_q;
        out_badvaddr_d = out_badvaddr_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                op_d       = bus.in_op;
                lane_d     = bus.in_addr[1:0];
                out_rd_d   = bus.in_rd;
                out_load_d = is_load;
                if (exc_c != 2'd0) begin
                    state_d        = RESP;
                    out_valid_d    = 1'b1;
                    out_exc_d      = exc_c;
                    out_badvaddr_d = bus.in_addr;
                    out_data_d     = '0;
                end else begin
                    state_d     = BUS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = is_store;
                    mem_addr_d  = {bus.in_addr[31:2], 2'b00};
                    mem_be_d    = be_c;
                    mem_wdata_d = wd_c;
                end
            end
            BUS: if (bus.mem_ack) begin
                state_d        = RESP;
                mem_req_d      = 1'b0;
                out_valid_d    = 1'b1;
                out_exc_d      = 2'd0;
                out_badvaddr_d = '0;
                out_data_d     = load_c;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            op_q           <= '0;
            lane_q         <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_be_q       <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            out_valid_q    <= 1'b0;
            out_load_q     <= 1'b0;
            out_rd_q       <= '0;
            out_data_q     <= '0;
            out_exc_q      <= '0;
            out_badvaddr_q <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            lane_q         <= lane_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_be_q       <= mem_be_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            out_valid_q    <= out_valid_d;
            out_load_q     <= out_load_d;
            out_rd_q       <= out_rd_d;
            out_data_q     <= out_data_d;
            out_exc_q      <= out_exc_d;
            out_badvaddr_q <= out_badvaddr_d;
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_be       = mem_be_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_load     = out_load_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_exc      = out_exc_q;
    assign bus.out_badvaddr = out_badvaddr_q;
endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: loads, stores, exceptions,
// back-to-back ops and reset during a bus transaction.
module tb_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   req_rises = 0;
    int   valid_pulses = 0;
    int   exp_reqs = 0;
    int   exp_pulses = 0;
    logic req_prev = 1'b0;
    logic valid_prev = 1'b0;

    lsu_if bus();
    lsu u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Rising-edge counters for mem_req and out_valid, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_req && !req_prev) req_rises++;
        if (bus.out_valid && !valid_prev) valid_pulses++;
        req_prev   = bus.mem_req;
        valid_prev = bus.out_valid;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 10) begin
            tick();
            n++;
        end
        check("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic run_mem(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_data, input logic is_ld);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
        bus.in_rd    = rd;
        tick();
        bus.in_valid = 1'b0;
        exp_reqs++;
        exp_pulses++;
        for (int i = 0; i <= waits; i++) begin
            check("mem_req", {31'b0, bus.mem_req}, 32'd1);
            check("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
            check("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
            check("mem_be", {28'b0, bus.mem_be}, {28'b0, exp_be});
            check("mem_we", {31'b0, bus.mem_we}, {31'b0, ~is_ld});
            if (!is_ld) check("mem_wdata", bus.mem_wdata, exp_wd);
            check("out_valid_bus", {31'b0, bus.out_valid}, 32'd0);
            if (i == waits) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
            end
            tick();
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        check("out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("mem_req_drop", {31'b0, bus.mem_req}, 32'd0);
        check("out_load", {31'b0, bus.out_load}, {31'b0, is_ld});
        check("out_rd", {27'b0, bus.out_rd}, {27'b0, rd});
        check("out_data", bus.out_data, exp_data);
        check("out_exc", {30'b0, bus.out_exc}, 32'd0);
        check("out_badvaddr", bus.out_badvaddr, 32'd0);
        tick();
        check("out_valid_once", {31'b0, bus.out_valid}, 32'd0);
        check("in_ready_back", {31'b0, bus.in_ready}, 32'd1);
        check("out_data_hold", bus.out_data, exp_data);
    endtask

    task automatic run_exc(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [1:0] exp_exc);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_addr  = addr;
        bus.in_wdata = 32'hFFFF_FFFF;
        bus.in_rd    = rd;
        tick();
        bus.in_valid = 1'b0;
        exp_pulses++;
        check("exc_valid", {31'b0, bus.out_valid}, 32'd1);
        check("exc_code", {30'b0, bus.out_exc}, {30'b0, exp_exc});
        check("exc_badvaddr", bus.out_badvaddr, addr);
        check("exc_data", bus.out_data, 32'd0);
        check("exc_rd", {27'b0, bus.out_rd}, {27'b0, rd});
        check("exc_no_req", {31'b0, bus.mem_req}, 32'd0);
        tick();
        check("exc_valid_once", {31'b0, bus.out_valid}, 32'd0);
        check("exc_ready", {31'b0, bus.in_ready}, 32'd1);
        check("exc_hold", {30'b0, bus.out_exc}, {30'b0, exp_exc});
        check("exc_no_req2", {31'b0, bus.mem_req}, 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_addr   = '0;
        bus.in_wdata  = '0;
        bus.in_rd     = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_load", {31'b0, bus.out_load}, 32'd0);
        check("rst_out_rd", {27'b0, bus.out_rd}, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_exc", {30'b0, bus.out_exc}, 32'd0);
        check("rst_badvaddr", bus.out_badvaddr, 32'd0);
        rst = 1'b0;
        tick();

        // Stray ack in IDLE must be ignored.
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("idle_ack_valid", {31'b0, bus.out_valid}, 32'd0);
        check("idle_ack_ready", {31'b0, bus.in_ready}, 32'd1);

        run_mem(6'h23, 32'h0000_1004, 32'h0, 5'd3, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b1);
        run_mem(6'h20, 32'h0000_1003, 32'h0, 5'd4, 32'h80FF_7F01, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b1);
        run_mem(6'h24, 32'h0000_1003, 32'h0, 5'd4, 32'h80FF_7F01, 0, 4'b1000, 32'h0, 32'h0000_0080, 1'b1);
        run_mem(6'h21, 32'h0000_1002, 32'h0, 5'd6, 32'h80FF_7F01, 1, 4'b1100, 32'h0, 32'hFFFF_80FF, 1'b1);
        run_mem(6'h25, 32'h0000_1000, 32'h0, 5'd7, 32'h80FF_F701, 0, 4'b0011, 32'h0, 32'h0000_F701, 1'b1);
        run_mem(6'h20, 32'h0000_1001, 32'h0, 5'd8, 32'h80FF_7F01, 0, 4'b0010, 32'h0, 32'h0000_007F, 1'b1);
        run_mem(6'h29, 32'h0000_2002, 32'h1234_5678, 5'd9, 32'h5555_5555, 3, 4'b1100, 32'h5678_5678, 32'h0, 1'b0);
        run_mem(6'h28, 32'h0000_2001, 32'hAABB_CCDD, 5'd10, 32'h0, 1, 4'b0010, 32'hDDDD_DDDD, 32'h0, 1'b0);
        run_mem(6'h2b, 32'h0000_2000, 32'hCAFE_F00D, 5'd11, 32'h0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);

        run_exc(6'h23, 32'h0000_0006, 5'd12, 2'd1);
        run_exc(6'h2b, 32'h0000_0001, 5'd13, 2'd2);
        run_exc(6'h22, 32'h0000_0100, 5'd14, 2'd3);
        run_exc(6'h21, 32'h0000_1001, 5'd15, 2'd1);
        run_exc(6'h29, 32'h0000_2003, 5'd16, 2'd2);

        // Back-to-back: in_valid stays high; second op waits for in_ready.
        bus.in_valid = 1'b1;
        bus.in_op    = 6'h23;
        bus.in_addr  = 32'h0000_0010;
        bus.in_rd    = 5'd5;
        tick();
        exp_reqs += 2;
        exp_pulses += 2;
        bus.in_op    = 6'h24;
        bus.in_addr  = 32'h0000_0022;
        bus.in_rd    = 5'd9;
        check("b2b_req1", {31'b0, bus.mem_req}, 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1122_3344;
        tick();
        bus.mem_ack = 1'b0;
        check("b2b_valid1", {31'b0, bus.out_valid}, 32'd1);
        check("b2b_rd1", {27'b0, bus.out_rd}, 32'd5);
        check("b2b_data1", bus.out_data, 32'h1122_3344);
        check("b2b_not_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        check("b2b_ready", {31'b0, bus.in_ready}, 32'd1);
        check("b2b_idle_req", {31'b0, bus.mem_req}, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_req2", {31'b0, bus.mem_req}, 32'd1);
        check("b2b_addr2", bus.mem_addr, 32'h0000_0020);
        check("b2b_be2", {28'b0, bus.mem_be}, 32'b0100);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h00A5_0000;
        tick();
        bus.mem_ack = 1'b0;
        check("b2b_valid2", {31'b0, bus.out_valid}, 32'd1);
        check("b2b_rd2", {27'b0, bus.out_rd}, 32'd9);
        check("b2b_data2", bus.out_data, 32'h0000_00A5);
        tick();

        // Reset coincident with ack during BUS: ack discarded.
        bus.in_valid = 1'b1;
        bus.in_op    = 6'h23;
        bus.in_addr  = 32'h0000_3000;
        bus.in_rd    = 5'd17;
        tick();
        bus.in_valid = 1'b0;
        exp_reqs++;
        check("rst_bus_req", {31'b0, bus.mem_req}, 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_ack = 1'b0;
        check("rstbus_req", {31'b0, bus.mem_req}, 32'd0);
        check("rstbus_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rstbus_valid", {31'b0, bus.out_valid}, 32'd0);
        tick();
        check("rstbus_valid2", {31'b0, bus.out_valid}, 32'd0);
        run_mem(6'h23, 32'h0000_3008, 32'h0, 5'd18, 32'h0BAD_F00D, 2, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b1);

        tick();
        check("req_count", req_rises, exp_reqs);
        check("valid_count", valid_pulses, exp_pulses);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the sbmips execute→memory boundary. It takes the effective address computed by the ALU (`add` result of base + offset) together with the store data and the memory opcode. It runs one transaction on a simple request/acknowledge data-memory bus, then hands an aligned, sign- or zero-extended load result to writeback. It also flags address-alignment exceptions without touching the bus.

## Interface
Parameters:
- none

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: execute stage presents an operation.
- `in_ready` output 1: unit can accept; high only in IDLE.
- `in_op` input 6: MIPS primary opcode. Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25. Stores: sb 0x28, sh 0x29, sw 0x2b.
- `in_addr` input 32: effective byte address (ALU output).
- `in_wdata` input 32: store data (rt value); ignored for loads.
- `in_rd` input 5: load destination register; carried through unchanged.
- `mem_req` output 1: bus request; held until acknowledged.
- `mem_we` output 1: 1 = write.
- `mem_be` output 4: byte enables; bit i = byte lane i, little-endian.
- `mem_addr` output 32: word address, bits [1:0] always 0.
- `mem_wdata` output 32: store data replicated into the selected lanes.
- `mem_ack` input 1: bus completes the request in the cycle it is high while `mem_req`=1.
- `mem_rdata` input 32: read word; valid in the `mem_ack` cycle.
- `out_valid` output 1: one-cycle completion pulse.
- `out_load` output 1: completed op was a load (writeback enable if no exception).
- `out_rd` output 5: destination register of the completed op.
- `out_data` output 32: extended load result; 0 for stores and exceptions.
- `out_exc` output 2: 0 none, 1 misaligned load (AdEL), 2 misaligned store (AdES), 3 illegal opcode.
- `out_badvaddr` output 32: `in_addr` of the faulting op; 0 when `out_exc`=0.

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - On `in_valid`, latch op, addr, wdata and rd.
  - If the op is aligned and legal, go to BUS.
  - Otherwise go to RESP with `out_exc` set and no bus activity.
  - Alignment rules: halfword needs addr[0]=0; word needs addr[1:0]=0.
- BUS:
  - `mem_req`=1 with `mem_addr`={addr[31:2],2'b00}.
  - Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - `mem_wdata`: sb = {4{b[7:0]}}; sh = {2{b[15:0]}}; sw = b.
  - All bus outputs are registered and stable while `mem_req`=1.
  - On `mem_ack`, capture `mem_rdata` and go to RESP.
- RESP:
  - `out_valid`=1 for exactly one cycle, then return to IDLE unconditionally. Writeback never stalls.
- Load extraction:
  - Select byte lane addr[1:0], or halfword lane addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Outputs outside RESP:
  - `out_valid`=0.
  - `out_data`, `out_exc`, `out_badvaddr` hold their last values.
- Reset values: `in_ready`=1 (IDLE), `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `out_valid`=0, `out_load`=0, `out_rd`=0, `out_data`=0, `out_exc`=0, `out_badvaddr`=0.

## Timing
- Accept at edge E0 (`in_valid`&`in_ready`). `mem_req` is high from cycle E0+1.
- `mem_ack` is sampled at each edge while in BUS; a zero-wait ack in the first BUS cycle is legal.
- After the ack edge Ea, `out_valid` is high in cycle Ea+1 and `in_ready` returns in cycle Ea+2.
- Minimum memory-op latency: accept→`out_valid` = 2 cycles; throughput is one op per 3 cycles.
- Exception or illegal op: `out_valid` in cycle E0+1, `in_ready` again in E0+2; `mem_req` never asserts.
- `mem_ack` while `mem_req`=0 is ignored.
- `in_valid` while `in_ready`=0 is ignored; upstream must hold it.
- `rst` in any state:
  - IDLE next cycle; `mem_req` and `out_valid` drop at that edge.
  - A `mem_ack` coinciding with the reset edge is discarded and produces no `out_valid`.

## Test plan
- lw at 0x00001004, `mem_rdata`=0xDEADBEEF, ack in first BUS cycle → `mem_addr`=0x00001004, `mem_be`=4'b1111, `mem_we`=0; `out_valid` 2 cycles after accept with `out_data`=0xDEADBEEF, `out_exc`=0.
- lb/lbu at 0x00001003, `mem_rdata`=0x80FF7F01 → lb gives 0xFFFFFF80, lbu gives 0x00000080, `mem_be`=4'b1000; lh at 0x00001002 gives 0xFFFF80FF.
- sh at 0x00002002, wdata 0x12345678, ack delayed 3 cycles → `mem_req`, `mem_addr`=0x00002000, `mem_be`=4'b1100, `mem_wdata`=0x56785678 held stable for all 3 wait cycles; `out_valid` once, `out_load`=0, `out_data`=0.
- lw at 0x00000006 and sw at 0x00000001 → no `mem_req`; `out_valid` the cycle after accept with `out_exc`=1 / 2 respectively and `out_badvaddr`=0x00000006 / 0x00000001. Opcode 0x22 → `out_exc`=3.
- Back-to-back: `in_valid` held high with two ops → second accepted only when `in_ready` returns; exactly one `mem_req` assertion per op, and `out_rd` matches each op's `in_rd`.
- `rst` asserted during BUS, coincident with `mem_ack` → `mem_req`=0 and state IDLE the following cycle; `out_valid` never pulses; the next lw completes normally.
